// File: rtl/power_on_reset_sequencer_if.sv
// Power-good input and sequenced reset outputs of the power-on reset sequencer.
// Master modport is the sequencer side; slave modport is the power source / reset consumer side.
interface power_on_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   power;
  logic [NUM_DOMAINS-1:0] sys_reset_n;
  logic                   ready;
  logic [1:0]             state;
  logic                   tick;
  logic [7:0]             brownout_count;

  modport master (
    input  power,
    output sys_reset_n, ready, state, tick, brownout_count
  );

  modport slave (
    output power,
    input  sys_reset_n, ready, state, tick, brownout_count
  );
endinterface

// File: rtl/power_on_reset_sequencer.sv
// Releases per-domain resets in order once synchronized power is stable, then runs a tick divider.
// Power-good reaches the FSM 2 cycles late; all outputs registered; no backpressure (free-running).
module power_on_reset_sequencer #(
  parameter int STABLE_CYCLES = 16,
  parameter int NUM_DOMAINS   = 3,
  parameter int STAGE_GAP     = 4,
  parameter int TICK_DIV      = 10
) (
  input  logic                              clock,
  input  logic                              reset_n,
  power_on_reset_sequencer_if.master        bus
);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);

  state_t                 state_q, state_d;
  logic                   sync_q, power_s;
  logic [SW-1:0]          stable_q, stable_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   tick_q, tick_d;
  logic [7:0]             bo_q, bo_d;

  // power is asynchronous to clock; only power_s may steer the FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 1'b0;
      power_s <= 1'b0;
    end else begin
      sync_q  <= bus.power;
      power_s <= sync_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OFF;
      stable_q   <= '0;
      gap_q      <= '0;
      tick_cnt_q <= '0;
      dom_q      <= '0;
      ready_q    <= 1'b0;
      tick_q     <= 1'b0;
      bo_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      stable_q   <= stable_d;
      gap_q      <= gap_d;
      tick_cnt_q <= tick_cnt_d;
      dom_q      <= dom_d;
      ready_q    <= ready_d;
      tick_q     <= tick_d;
      bo_q       <= bo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stable_d   = stable_q;
    gap_d      = gap_q;
    tick_cnt_d = tick_cnt_q;
    dom_d      = dom_q;
    ready_d    = ready_q;
    tick_d     = 1'b0;
    bo_d       = bo_q;

    // Power loss outranks every counter-terminal transition
    if (state_q != OFF && !power_s) begin
      state_d    = OFF;
      stable_d   = '0;
      gap_d      = '0;
      tick_cnt_d = '0;
      dom_d      = '0;
      ready_d    = 1'b0;
      if (state_q != STABILIZE && bo_q != 8'hFF) begin
        bo_d = bo_q + 8'd1;
      end
    end else begin
      case (state_q)
        OFF: begin
          stable_d   = '0;
          gap_d      = '0;
          tick_cnt_d = '0;
          dom_d      = '0;
          ready_d    = 1'b0;
          if (power_s) begin
            state_d = STABILIZE;
          end
        end
        STABILIZE: begin
          if (stable_q == STABLE_LAST) begin
            state_d  = RELEASE;
            stable_d = '0;
            gap_d    = '0;
            dom_d    = NUM_DOMAINS'(1);
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (&dom_q) begin
              state_d    = RUN;
              ready_d    = 1'b1;
              tick_cnt_d = '0;
            end else begin
              dom_d = (dom_q << 1) | NUM_DOMAINS'(1);
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign bus.sys_reset_n    = dom_q;
  assign bus.ready          = ready_q;
  assign bus.state          = state_q;
  assign bus.tick           = tick_q;
  assign bus.brownout_count = bo_q;

endmodule
